// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: tracks in-flight destination registers to drive
// load-use stalls, taken-branch flushes, EX operand forwarding and saturating event counters.
module hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_valid_i,
  input  logic [4:0]       d_rs_i,
  input  logic [4:0]       d_rt_i,
  input  logic             d_use_rs_i,
  input  logic             d_use_rt_i,
  input  logic             d_regwrite_i,
  input  logic             d_memread_i,
  input  logic [4:0]       d_dst_i,
  input  logic             m_pc_src_i,
  output logic             stall_o,
  output logic             bubble_ex_o,
  output logic             flush_ifid_o,
  output logic             flush_idex_o,
  output logic             flush_exmem_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memread;
    logic [4:0] dst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
  } ex_ent_t;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic [4:0] dst;
  } wr_ent_t;

  ex_ent_t          ex_q, ex_d, id_ent;
  wr_ent_t          mem_q, mem_d, wb_q, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             fl, lu, ex_live, mem_live, wb_live;

  function automatic logic [1:0] fwd_sel(input logic       use_src,
                                         input logic [4:0] src,
                                         input logic       m_live,
                                         input logic [4:0] m_dst,
                                         input logic       w_live,
                                         input logic [4:0] w_dst);
    logic [1:0] sel;
    sel = 2'b00;
    if (use_src && m_live && (m_dst == src)) begin
      sel = 2'b01;
    end else if (use_src && w_live && (w_dst == src)) begin
      sel = 2'b10;
    end
    return sel;
  endfunction

  assign ex_live  = ex_q.valid & ex_q.regwrite & (ex_q.dst != 5'd0);
  assign mem_live = mem_q.valid & mem_q.regwrite & (mem_q.dst != 5'd0);
  assign wb_live  = wb_q.valid & wb_q.regwrite & (wb_q.dst != 5'd0);

  // Shadow state is all bubbles in reset, so only the flush input needs explicit gating.
  assign fl = m_pc_src_i & ~rst;
  assign lu = ex_live & ex_q.memread & d_valid_i &
              ((d_use_rs_i & (d_rs_i == ex_q.dst)) | (d_use_rt_i & (d_rt_i == ex_q.dst)));

  always_comb begin
    stall_o       = 1'b0;
    bubble_ex_o   = 1'b0;
    flush_ifid_o  = 1'b0;
    flush_idex_o  = 1'b0;
    flush_exmem_o = 1'b0;
    if (fl) begin
      flush_ifid_o  = 1'b1;
      flush_idex_o  = 1'b1;
      flush_exmem_o = 1'b1;
    end else if (lu) begin
      stall_o     = 1'b1;
      bubble_ex_o = 1'b1;
    end
  end

  assign fwd_a_o = fwd_sel(ex_q.valid & ex_q.use_rs, ex_q.rs, mem_live, mem_q.dst,
                           wb_live, wb_q.dst);
  assign fwd_b_o = fwd_sel(ex_q.valid & ex_q.use_rt, ex_q.rt, mem_live, mem_q.dst,
                           wb_live, wb_q.dst);

  always_comb begin
    id_ent = '0;
    if (d_valid_i) begin
      id_ent.valid    = 1'b1;
      id_ent.regwrite = d_regwrite_i;
      id_ent.memread  = d_memread_i;
      id_ent.dst      = d_dst_i;
      id_ent.rs       = d_rs_i;
      id_ent.rt       = d_rt_i;
      id_ent.use_rs   = d_use_rs_i;
      id_ent.use_rt   = d_use_rt_i;
    end
    ex_d           = id_ent;
    mem_d.valid    = ex_q.valid;
    mem_d.regwrite = ex_q.regwrite;
    mem_d.dst      = ex_q.dst;
    wb_d           = mem_q;
    if (fl) begin
      // The branch in MEM still retires into WB; everything younger is killed.
      ex_d  = '0;
      mem_d = '0;
    end else if (lu) begin
      ex_d = '0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (fl && (flush_cnt_q != '1))      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a per-cycle vector table over short instruction sequences,
// then hand-written reset and counter-saturation sequences.
module tb_hazard_ctrl;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          d_valid, d_use_rs, d_use_rt, d_regwrite, d_memread, m_pc_src;
  logic [4:0]    d_rs, d_rt, d_dst;
  logic          stall, bubble_ex, flush_ifid, flush_idex, flush_exmem;
  logic [1:0]    fwd_a, fwd_b;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .d_valid_i    (d_valid),
    .d_rs_i       (d_rs),
    .d_rt_i       (d_rt),
    .d_use_rs_i   (d_use_rs),
    .d_use_rt_i   (d_use_rt),
    .d_regwrite_i (d_regwrite),
    .d_memread_i  (d_memread),
    .d_dst_i      (d_dst),
    .m_pc_src_i   (m_pc_src),
    .stall_o      (stall),
    .bubble_ex_o  (bubble_ex),
    .flush_ifid_o (flush_ifid),
    .flush_idex_o (flush_idex),
    .flush_exmem_o(flush_exmem),
    .fwd_a_o      (fwd_a),
    .fwd_b_o      (fwd_b),
    .stall_cnt_o  (stall_cnt),
    .flush_cnt_o  (flush_cnt)
  );

  typedef struct {
    int v, rs, rt, urs, urt, rw, mr, dst, pc;
    int e_st, e_bu, e_fl, e_fa, e_fb, e_sc, e_fc;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(int v, int rs, int rt, int urs, int urt, int rw, int mr, int dst,
                              int pc, int st, int bu, int fl, int fa, int fb, int sc, int fc);
    vec_t r;
    r.v = v; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt; r.rw = rw; r.mr = mr;
    r.dst = dst; r.pc = pc; r.e_st = st; r.e_bu = bu; r.e_fl = fl; r.e_fa = fa; r.e_fb = fb;
    r.e_sc = sc; r.e_fc = fc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic present(input int v, input int rs, input int rt, input int urs, input int urt,
                         input int rw, input int mr, input int dst, input int pc);
    d_valid    = v[0];
    d_rs       = 5'(rs);
    d_rt       = 5'(rt);
    d_use_rs   = urs[0];
    d_use_rt   = urt[0];
    d_regwrite = rw[0];
    d_memread  = mr[0];
    d_dst      = 5'(dst);
    m_pc_src   = pc[0];
  endtask

  task automatic chk_ctrl_zero(input string tag);
    chk({tag, " stall"}, 32'(stall), 0);
    chk({tag, " bubble_ex"}, 32'(bubble_ex), 0);
    chk({tag, " flush_ifid"}, 32'(flush_ifid), 0);
    chk({tag, " flush_idex"}, 32'(flush_idex), 0);
    chk({tag, " flush_exmem"}, 32'(flush_exmem), 0);
    chk({tag, " fwd_a"}, 32'(fwd_a), 0);
    chk({tag, " fwd_b"}, 32'(fwd_b), 0);
  endtask

  initial begin
    int exp_sc;
    // Rows: ALU fwd (0-2), one-between fwd (3-6), r0 dest (7-9), load-use (10-13),
    // branch flush (14-18), flush + load-use together (19-21).
    tbl[0]  = mk(1, 1, 2, 1, 1, 1, 0, 4, 0,  0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 4, 4, 1, 1, 1, 0, 6, 0,  0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 0, 0);
    tbl[3]  = mk(1, 1, 2, 1, 1, 1, 0, 7, 0,  0, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 1, 2, 1, 1, 1, 0, 8, 0,  0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 7, 7, 1, 1, 1, 0, 9, 0,  0, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2, 2, 0, 0);
    tbl[7]  = mk(1, 1, 2, 1, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(1, 0, 0, 1, 1, 1, 0, 5, 0,  0, 0, 0, 0, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(1, 2, 0, 1, 0, 1, 1, 1, 0,  0, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk(1, 1, 2, 1, 1, 1, 0, 3, 0,  1, 1, 0, 0, 0, 1, 0);
    tbl[12] = mk(1, 1, 2, 1, 1, 1, 0, 3, 0,  0, 0, 0, 0, 0, 1, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2, 0, 1, 0);
    tbl[14] = mk(1, 1, 2, 1, 1, 1, 0, 10, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[15] = mk(1, 10, 10, 1, 1, 1, 0, 11, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[16] = mk(1, 11, 10, 1, 1, 1, 0, 12, 1, 0, 0, 1, 1, 1, 1, 1);
    tbl[17] = mk(1, 11, 10, 1, 1, 1, 0, 13, 0, 0, 0, 0, 0, 0, 1, 1);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 1);
    tbl[19] = mk(1, 1, 0, 1, 0, 1, 1, 20, 0, 0, 0, 0, 0, 0, 1, 1);
    tbl[20] = mk(1, 20, 20, 1, 1, 1, 0, 21, 1, 0, 0, 1, 0, 0, 1, 2);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 2);

    rst = 1'b1;
    present(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_ctrl_zero("por");
    chk("por stall_cnt", 32'(stall_cnt), 0);
    chk("por flush_cnt", 32'(flush_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 22; i++) begin
      present(tbl[i].v, tbl[i].rs, tbl[i].rt, tbl[i].urs, tbl[i].urt, tbl[i].rw, tbl[i].mr,
              tbl[i].dst, tbl[i].pc);
      #1;
      chk($sformatf("row%0d stall", i), 32'(stall), tbl[i].e_st);
      chk($sformatf("row%0d bubble_ex", i), 32'(bubble_ex), tbl[i].e_bu);
      chk($sformatf("row%0d flush_ifid", i), 32'(flush_ifid), tbl[i].e_fl);
      chk($sformatf("row%0d flush_idex", i), 32'(flush_idex), tbl[i].e_fl);
      chk($sformatf("row%0d flush_exmem", i), 32'(flush_exmem), tbl[i].e_fl);
      chk($sformatf("row%0d fwd_a", i), 32'(fwd_a), tbl[i].e_fa);
      chk($sformatf("row%0d fwd_b", i), 32'(fwd_b), tbl[i].e_fb);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d stall_cnt", i), 32'(stall_cnt), tbl[i].e_sc);
      chk($sformatf("row%0d flush_cnt", i), 32'(flush_cnt), tbl[i].e_fc);
    end

    // Reset mid-stream with a load of r5 sitting in EX and a branch pending.
    present(1, 1, 0, 1, 0, 1, 1, 5, 0);
    @(posedge clk);
    #1;
    present(1, 5, 5, 1, 1, 1, 0, 6, 1);
    rst = 1'b1;
    #1;
    chk_ctrl_zero("rst");
    chk("rst stall_cnt", 32'(stall_cnt), 0);
    chk("rst flush_cnt", 32'(flush_cnt), 0);
    @(posedge clk);
    #1;
    chk("rst hold flush_cnt", 32'(flush_cnt), 0);
    present(1, 5, 0, 1, 0, 1, 1, 7, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-rst r5 read stall", 32'(stall), 0);
    @(posedge clk);
    #1;
    present(1, 7, 0, 1, 0, 1, 0, 8, 0);
    #1;
    chk("post-rst first load stall", 32'(stall), 1);
    @(posedge clk);
    #1;
    chk("post-rst stall_cnt", 32'(stall_cnt), 1);
    exp_sc = 1;

    // Repeated load-use pairs drive stall_cnt into saturation.
    for (int k = 0; k < 21; k++) begin
      present(1, 1, 0, 1, 0, 1, 1, 7, 0);
      @(posedge clk);
      #1;
      present(1, 7, 7, 1, 1, 1, 0, 9, 0);
      #1;
      chk($sformatf("sat%0d stall", k), 32'(stall), 1);
      @(posedge clk);
      #1;
      if (exp_sc < 15) exp_sc++;
      chk($sformatf("sat%0d stall_cnt", k), 32'(stall_cnt), exp_sc);
    end
    chk("sat final stall_cnt", 32'(stall_cnt), 15);
    chk("sat flush_cnt untouched", 32'(flush_cnt), 0);

    present(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
